replica_exchanger: RTL and testbench
====================================

REPLICA_EXCHANGER -- requirements
Module: replica_exchanger

Interface
REQ-001 The block SHALL have parameter id, default 0, the replica index in the chain.
REQ-002 The block SHALL have parameter city_num, default 30, the number of ordering words per replica.
REQ-003 The block SHALL have parameter city_w, default 8, the width of one ordering word.
REQ-004 The block SHALL have port clk  input  1  the single clock.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port exchange_cmd  input  exchange_command_t  per-cycle command: NOP, SELF, PREV or FOLW.
REQ-007 The block SHALL have port prev_city  input  city_w  the out_city of replica id-1.
REQ-008 The block SHALL have port folw_city  input  city_w  the out_city of replica id+1.
REQ-009 The block SHALL have port out_city  output  city_w  the ordering word streamed to both neighbours.
REQ-010 The block SHALL have port prev_total  input  total_data_t  the total distance of replica id-1.
REQ-011 The block SHALL have port folw_total  input  total_data_t  the total distance of replica id+1.
REQ-012 The block SHALL have port self_total  output  total_data_t  this replica's total distance.
REQ-013 The block SHALL have port busy  output  1  high while a burst is in progress.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-015 The block SHALL have port cmd_error  output  1  sticky flag for a command received while busy.
REQ-016 The block SHALL have port clear_error  input  1  clears cmd_error.
REQ-017 The block SHALL have port rd_addr  input  $clog2(city_num)  local read address.
REQ-018 The block SHALL have port rd_data  output  city_w  local read data.

Function
REQ-019 When idle, the block SHALL accept any non-NOP exchange_cmd: latch it, set idx=0, and assert busy from the next cycle.
REQ-020 The block SHALL have source prev_total (PREV), folw_total (FOLW) or self_total (SELF), and SHALL load that value into self_total at the accept edge.
REQ-021 In each busy cycle k, 0..city_num-1, out_city SHALL equal ordering[k], driven combinationally from the stored array.
REQ-022 In each busy cycle k, ordering[k] SHALL be written at that cycle's edge with prev_city (PREV), folw_city (FOLW) or ordering[k] (SELF).
REQ-023 A SELF burst SHALL run the full city_num cycles so that neighbours stay in lockstep.
REQ-024 Because every neighbour reads before it writes, a PREV/FOLW pair SHALL swap whole orderings.
REQ-025 At idx=city_num-1, idx SHALL wrap to 0, busy SHALL deassert at the next edge, and done SHALL pulse for exactly that one cycle.
REQ-026 out_city SHALL be 0 when not busy.
REQ-027 A non-NOP command while busy SHALL be ignored and SHALL set cmd_error.
REQ-028 clear_error SHALL clear cmd_error; when clear and a new error occur in the same cycle, the set SHALL win.
REQ-029 A command arriving in the done cycle SHALL be accepted, so bursts can run back-to-back with busy low for exactly one cycle.
REQ-030 rd_data SHALL be registered with 1-cycle latency: rd_data = ordering[rd_addr] as it was before that edge.
REQ-031 rd_data SHALL be 0 for rd_addr >= city_num.

Reset
REQ-032 Asynchronous reset SHALL force: idx=0, busy=0, done=0, cmd_error=0, rd_data=0, self_total=0, latched command=NOP, ordering[k]=k for all k.
REQ-033 Reset asserted mid-burst SHALL abort the burst, with no partial write after release.
REQ-034 Commands SHALL be ignored while reset is high.

Configuration
REQ-035 With REPLICA_EXCHANGER_STAT_EN defined, the block SHALL add output xchg_count, 16 bits, counting accepted PREV/FOLW commands; it SHALL saturate at 0xFFFF, reset to 0, and not count SELF.
REQ-036 Without REPLICA_EXCHANGER_STAT_EN, the xchg_count port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-037 A bench SHALL cover: with city_num=4 after reset, a SELF command -> busy for 4 cycles, out_city 0,1,2,3, ordering unchanged, done pulses once.
REQ-038 A bench SHALL cover: replicas A (id0) and B (id1) loaded {3,2,1,0} and {0,1,2,3}, B gets PREV and A gets FOLW -> A={0,1,2,3}, B={3,2,1,0}, and the self_totals swap.
REQ-039 A bench SHALL cover: a PREV command at burst cycle 2 -> ignored, cmd_error=1 until clear_error; clear_error together with a new error -> cmd_error stays 1.
REQ-040 A bench SHALL cover: reset asserted at burst cycle 1 -> busy=0 immediately, ordering={0,1,2,3}, no done pulse.
REQ-041 A bench SHALL cover: a FOLW command in the done cycle -> new burst starts, busy low exactly one cycle; rd_addr=5 -> rd_data=0.
REQ-042 With REPLICA_EXCHANGER_STAT_EN, a bench SHALL cover: 3 PREV, 2 SELF and 1 FOLW commands -> xchg_count=4.

Source files
------------

// File: rtl/replica_exchanger.sv
// replica_exchanger -- one replica's slot in a chain of annealing replicas.
//
// Holds a city ordering of city_num words, each city_w bits wide, plus the
// replica's total distance. A burst streams the stored ordering to both
// neighbours one word per cycle. At the same time it overwrites each word with
// the matching word from the previous neighbour (PREV), from the following
// neighbour (FOLW), or with itself (SELF). Each neighbour reads a word before
// it writes that word, so a PREV burst on one replica paired with a FOLW burst
// on its neighbour swaps the two orderings whole.
//
// Optional feature: define REPLICA_EXCHANGER_STAT_EN to add the xchg_count
// output, which counts accepted PREV/FOLW commands and saturates at 0xFFFF.
//
// Ports:
//   clk          single clock
//   reset        asynchronous, active-high reset
//   exchange_cmd per-cycle command (NOP/SELF/PREV/FOLW); accepted when idle
//   prev_city    out_city of replica id-1
//   folw_city    out_city of replica id+1
//   out_city     ordering word streamed to both neighbours (0 when idle)
//   prev_total   total distance of replica id-1
//   folw_total   total distance of replica id+1
//   self_total   this replica's total distance
//   busy         high while a burst is in progress
//   done         one-cycle pulse in the cycle after the last burst cycle
//   cmd_error    sticky flag: a command arrived while busy
//   clear_error  clears cmd_error (a new error in the same cycle wins)
//   rd_addr      local read address
//   rd_data      registered read data (0 for out-of-range addresses)
//   xchg_count   (REPLICA_EXCHANGER_STAT_EN only) accepted PREV/FOLW count

package replica_exchanger_pkg;
  typedef enum logic [1:0] {
    NOP  = 2'd0,
    SELF = 2'd1,
    PREV = 2'd2,
    FOLW = 2'd3
  } exchange_command_t;

  typedef logic [31:0] total_data_t;
endpackage

module replica_exchanger
  import replica_exchanger_pkg::*;
#(
  parameter int id       = 0,
  parameter int city_num = 30,
  parameter int city_w   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  exchange_command_t           exchange_cmd,
  input  logic [city_w-1:0]           prev_city,
  input  logic [city_w-1:0]           folw_city,
  output logic [city_w-1:0]           out_city,
  input  total_data_t                 prev_total,
  input  total_data_t                 folw_total,
  output total_data_t                 self_total,
  output logic                        busy,
  output logic                        done,
  output logic                        cmd_error,
  input  logic                        clear_error,
  input  logic [$clog2(city_num)-1:0] rd_addr,
  output logic [city_w-1:0]           rd_data
`ifdef REPLICA_EXCHANGER_STAT_EN
  ,
  output logic [15:0]                 xchg_count
`endif
);

  localparam int AW  = $clog2(city_num);
  localparam int AW1 = AW + 1;
  localparam logic [AW-1:0] LAST_IDX     = AW'(city_num - 1);
  localparam logic [AW:0]   CITY_NUM_EXT = AW1'(city_num);

  // The rest of the design assumes at least two words and a chain position.
  if (city_num < 2 || id < 0) begin : g_bad_params
    $error("replica_exchanger: city_num must be >= 2 and id >= 0");
  end

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t            state;
  exchange_command_t cmd_q;
  logic [AW-1:0]     idx;
  logic [city_w-1:0] ordering [city_num];
  logic              accept;
  logic [city_w-1:0] cur_city;
  logic [city_w-1:0] wr_city;
  total_data_t       load_total;

  assign busy     = (state == ST_BURST);
  assign accept   = (state == ST_IDLE) && (exchange_cmd != NOP);
  assign cur_city = ordering[idx];
  assign out_city = busy ? cur_city : '0;

  // Word written back in the current burst cycle, chosen by the latched command.
  always_comb begin
    wr_city = cur_city;
    case (cmd_q)
      PREV:    wr_city = prev_city;
      FOLW:    wr_city = folw_city;
      default: wr_city = cur_city;
    endcase
  end

  // Total distance that moves with the ordering, picked from the new command.
  always_comb begin
    load_total = self_total;
    case (exchange_cmd)
      PREV:    load_total = prev_total;
      FOLW:    load_total = folw_total;
      default: load_total = self_total;
    endcase
  end

  // Burst sequencer: IDLE accepts a command. BURST walks idx across the ordering,
  // writing one word per cycle, and returns to IDLE with a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd_q      <= NOP;
      idx        <= '0;
      done       <= 1'b0;
      self_total <= '0;
      for (int k = 0; k < city_num; k++) begin
        ordering[k] <= city_w'(k);
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_BURST;
            cmd_q      <= exchange_cmd;
            idx        <= '0;
            self_total <= load_total;
          end
        end
        ST_BURST: begin
          ordering[idx] <= wr_city;
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
            idx   <= '0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error for commands that arrive mid-burst. A new error beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_error <= 1'b0;
    end else if (busy && (exchange_cmd != NOP)) begin
      cmd_error <= 1'b1;
    end else if (clear_error) begin
      cmd_error <= 1'b0;
    end
  end

  // Local read port. It returns the word as it was before this edge's burst
  // write, and 0 for addresses beyond the ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < CITY_NUM_EXT) begin
      rd_data <= ordering[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

`ifdef REPLICA_EXCHANGER_STAT_EN
  // Counts exchanges with neighbours only. SELF bursts do not move data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xchg_count <= '0;
    end else if (accept && ((exchange_cmd == PREV) || (exchange_cmd == FOLW))
                 && (xchg_count != 16'hFFFF)) begin
      xchg_count <= xchg_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_replica_exchanger.sv
// tb_replica_exchanger -- directed bench for replica_exchanger.
// Replica A (id 0) and replica B (id 1) are chained with city_num=4. The bench
// drives A's previous neighbour and B's following neighbour directly. A third
// instance C (city_num=5) has a 3-bit read address, so it can exercise reads
// beyond the end of the ordering.
module tb_replica_exchanger;
  import replica_exchanger_pkg::*;

  localparam int CN = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  exchange_command_t cmd_a, cmd_b, cmd_c;
  logic [CW-1:0] tb_prev_city, tb_folw_city;
  total_data_t tb_prev_total, tb_folw_total;
  logic clear_error;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic [2:0] rd_addr_c;

  logic [CW-1:0] out_a, out_b, out_c, rd_data_a, rd_data_b, rd_data_c;
  total_data_t total_a, total_b, total_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic err_a, err_b, err_c;
`ifdef REPLICA_EXCHANGER_STAT_EN
  logic [15:0] xchg_a, xchg_b, xchg_c;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  replica_exchanger #(.id(0), .city_num(CN), .city_w(CW)) u_a (
    .clk(clk), .reset(reset), .exchange_cmd(cmd_a),
    .prev_city(tb_prev_city), .folw_city(out_b), .out_city(out_a),
    .prev_total(tb_prev_total), .folw_total(total_b), .self_total(total_a),
    .busy(busy_a), .done(done_a), .cmd_error(err_a), .clear_error(clear_error),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a)
`ifdef REPLICA_EXCHANGER_STAT_EN
    , .xchg_count(xchg_a)
`endif
  );

  replica_exchanger #(.id(1), .city_num(CN), .city_w(CW)) u_b (
    .clk(clk), .reset(reset), .exchange_cmd(cmd_b),
    .prev_city(out_a), .folw_city(tb_folw_city), .out_city(out_b),
    .prev_total(total_a), .folw_total(tb_folw_total), .self_total(total_b),
    .busy(busy_b), .done(done_b), .cmd_error(err_b), .clear_error(clear_error),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b)
`ifdef REPLICA_EXCHANGER_STAT_EN
    , .xchg_count(xchg_b)
`endif
  );

  replica_exchanger #(.id(2), .city_num(5), .city_w(CW)) u_c (
    .clk(clk), .reset(reset), .exchange_cmd(cmd_c),
    .prev_city('0), .folw_city('0), .out_city(out_c),
    .prev_total('0), .folw_total('0), .self_total(total_c),
    .busy(busy_c), .done(done_c), .cmd_error(err_c), .clear_error(clear_error),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c)
`ifdef REPLICA_EXCHANGER_STAT_EN
    , .xchg_count(xchg_c)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Presents one command per replica for a single cycle. Returns in burst cycle 0.
  task automatic applyStimulus(input exchange_command_t a, input exchange_command_t b);
    cmd_a = a;
    cmd_b = b;
    tick();
    cmd_a = NOP;
    cmd_b = NOP;
  endtask

  // Walks the four burst cycles, feeding the bench-side neighbours and
  // optionally checking busy and the streamed words. Byte k of each packed
  // word is ordering position k.
  task automatic runBurst(input string tag, input logic [31:0] feed_prev,
                          input logic [31:0] feed_folw,
                          input logic chk_a, input logic [31:0] exp_a,
                          input logic chk_b, input logic [31:0] exp_b);
    for (int k = 0; k < CN; k++) begin
      tb_prev_city = feed_prev[k*8 +: 8];
      tb_folw_city = feed_folw[k*8 +: 8];
      if (chk_a) begin
        checkOutput($sformatf("%s_busy_a%0d", tag, k), busy_a, 1);
        checkOutput($sformatf("%s_out_a%0d", tag, k), out_a, exp_a[k*8 +: 8]);
        checkOutput($sformatf("%s_done_a%0d", tag, k), done_a, 0);
      end
      if (chk_b) begin
        checkOutput($sformatf("%s_busy_b%0d", tag, k), busy_b, 1);
        checkOutput($sformatf("%s_out_b%0d", tag, k), out_b, exp_b[k*8 +: 8]);
      end
      tick();
    end
    tb_prev_city = '0;
    tb_folw_city = '0;
  endtask

  // Reads back both orderings through the registered read ports.
  task automatic checkOrders(input string tag, input logic [31:0] exp_a,
                             input logic [31:0] exp_b);
    for (int k = 0; k < CN; k++) begin
      rd_addr_a = 2'(k);
      rd_addr_b = 2'(k);
      tick();
      checkOutput($sformatf("%s_ord_a%0d", tag, k), rd_data_a, exp_a[k*8 +: 8]);
      checkOutput($sformatf("%s_ord_b%0d", tag, k), rd_data_b, exp_b[k*8 +: 8]);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_a = NOP; cmd_b = NOP; cmd_c = NOP;
    tb_prev_city = '0; tb_folw_city = '0;
    tb_prev_total = 32'd100; tb_folw_total = 32'd200;
    clear_error = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_done_a", done_a, 0);
    checkOutput("rst_err_a", err_a, 0);
    checkOutput("rst_out_a", out_a, 0);
    checkOutput("rst_total_a", total_a, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    checkOrders("rst", 32'h03020100, 32'h03020100);

    $display("[TB] SELF burst on A");
    applyStimulus(SELF, NOP);
    runBurst("self", 32'h0, 32'h0, 1'b1, 32'h03020100, 1'b0, 32'h0);
    checkOutput("self_end_busy", busy_a, 0);
    checkOutput("self_end_done", done_a, 1);
    tick();
    checkOutput("self_done_once", done_a, 0);
    checkOrders("self", 32'h03020100, 32'h03020100);

    $display("[TB] load A={3,2,1,0} and B={0,1,2,3}");
    applyStimulus(PREV, FOLW);
    runBurst("load", 32'h00010203, 32'h03020100, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("load_done_a", done_a, 1);
    checkOutput("load_done_b", done_b, 1);
    checkOutput("load_total_a", total_a, 100);
    checkOutput("load_total_b", total_b, 200);
    checkOrders("load", 32'h00010203, 32'h03020100);

    $display("[TB] swap: A FOLW, B PREV");
    applyStimulus(FOLW, PREV);
    runBurst("swap", 32'h0, 32'h0, 1'b1, 32'h00010203, 1'b1, 32'h03020100);
    checkOutput("swap_done_a", done_a, 1);
    checkOutput("swap_done_b", done_b, 1);
    checkOutput("swap_total_a", total_a, 200);
    checkOutput("swap_total_b", total_b, 100);
    checkOrders("swap", 32'h03020100, 32'h00010203);

    $display("[TB] command while busy");
    applyStimulus(NOP, SELF);
    tick();
    tick();
    cmd_b = PREV;
    tick();
    cmd_b = NOP;
    checkOutput("err_set", err_b, 1);
    checkOutput("err_still_busy", busy_b, 1);
    tick();
    checkOutput("err_burst_done", done_b, 1);
    checkOutput("err_sticky", err_b, 1);
    checkOutput("err_other_clean", err_a, 0);
    checkOrders("err", 32'h03020100, 32'h00010203);
    checkOutput("err_total_b", total_b, 100);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    checkOutput("err_cleared", err_b, 0);
    applyStimulus(NOP, SELF);
    cmd_b = FOLW;
    clear_error = 1'b1;
    tick();
    cmd_b = NOP;
    clear_error = 1'b0;
    checkOutput("err_set_wins", err_b, 1);
    repeat (3) tick();
    checkOutput("err2_done", done_b, 1);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    checkOutput("err2_cleared", err_b, 0);

    $display("[TB] reset mid-burst");
    applyStimulus(PREV, NOP);
    tb_prev_city = 8'd9;
    tick();
    checkOutput("mid_busy_before", busy_a, 1);
    reset = 1'b1;
    cmd_a = SELF;
    #1;
    checkOutput("mid_busy_async", busy_a, 0);
    checkOutput("mid_out_async", out_a, 0);
    tick();
    tick();
    reset = 1'b0;
    cmd_a = NOP;
    tb_prev_city = '0;
    tick();
    checkOutput("mid_busy_after", busy_a, 0);
    checkOutput("mid_done_after", done_a, 0);
    checkOutput("mid_total", total_a, 0);
    checkOrders("mid", 32'h03020100, 32'h03020100);
    checkOutput("mid_no_done", done_a, 0);

    $display("[TB] back-to-back bursts");
    applyStimulus(SELF, NOP);
    runBurst("b2b1", 32'h0, 32'h0, 1'b1, 32'h03020100, 1'b0, 32'h0);
    checkOutput("b2b_gap_busy", busy_a, 0);
    checkOutput("b2b_gap_done", done_a, 1);
    applyStimulus(FOLW, NOP);
    runBurst("b2b2", 32'h0, 32'h0, 1'b1, 32'h03020100, 1'b0, 32'h0);
    checkOutput("b2b_end_done", done_a, 1);
    checkOrders("b2b", 32'h00000000, 32'h03020100);

    $display("[TB] read range on C");
    rd_addr_c = 3'd4;
    tick();
    checkOutput("rd_c4", rd_data_c, 4);
    rd_addr_c = 3'd5;
    tick();
    checkOutput("rd_c5", rd_data_c, 0);
    rd_addr_c = 3'd7;
    tick();
    checkOutput("rd_c7", rd_data_c, 0);

`ifdef REPLICA_EXCHANGER_STAT_EN
    $display("[TB] exchange counter");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("stat_rst", xchg_a, 0);
    begin
      exchange_command_t seq [6];
      seq = '{PREV, PREV, SELF, PREV, SELF, FOLW};
      for (int i = 0; i < 6; i++) begin
        applyStimulus(seq[i], NOP);
        repeat (CN + 1) tick();
      end
    end
    checkOutput("stat_count_a", xchg_a, 4);
    checkOutput("stat_count_b", xchg_b, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
